// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a time-multiplexed 7-segment display bus, qualifies each
// digit over repeated scans, decodes glyphs back to hex nibbles and emits the assembled
// word on a valid/ready interface.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   seg_in[6:0]      segment lines (bit 6 = a .. bit 0 = g), asynchronous
//   an_in[DIGITS-1:0] one-hot digit strobes, bit 0 = least-significant digit, asynchronous
//   hex_out          decoded word, digit i at [4i+3:4i]
//   err_out          per-digit flag: glyph is not a hex glyph
//   out_valid/out_ready  word handshake
//   scan_err         one-cycle pulse on a non-one-hot, non-zero strobe pattern
// Optional: SEG7_SCAN_DP_CAPTURE_EN adds dp_in / dp_out[DIGITS-1:0]; the decimal point
// then takes part in the per-digit match and in the word-change comparison.
module seg7_scan_decoder #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned SETTLE_CYC     = 8,
    parameter int unsigned STABLE_SCANS   = 3,
    parameter int unsigned SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
`ifdef SEG7_SCAN_DP_CAPTURE_EN
    input  logic                  dp_in,
    output logic [DIGITS-1:0]     dp_out,
`endif
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     err_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  scan_err
);

    localparam int unsigned CNT_W  = $clog2(SETTLE_CYC);
    localparam int unsigned WORD_W = 4 * DIGITS;

    typedef enum logic [1:0] {SLOT_IDLE, SLOT_SETTLE, SLOT_HOLD} slot_e;
    typedef enum logic       {OUT_EMPTY, OUT_FULL} out_e;

    // Returns {err, nibble} for a lit-high abcdefg pattern.
    function automatic logic [4:0] decode_glyph(input logic [6:0] lit);
        logic [4:0] r;
        r = 5'h10;
        case (lit)
            7'h7E: r = 5'h00;  7'h30: r = 5'h01;  7'h6D: r = 5'h02;  7'h79: r = 5'h03;
            7'h33: r = 5'h04;  7'h5B: r = 5'h05;  7'h5F: r = 5'h06;  7'h70: r = 5'h07;
            7'h7F: r = 5'h08;  7'h7B: r = 5'h09;  7'h77: r = 5'h0A;  7'h1F: r = 5'h0B;
            7'h4E: r = 5'h0C;  7'h3D: r = 5'h0D;  7'h4F: r = 5'h0E;  7'h47: r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    logic [6:0]                seg_m_q, seg_m_d, seg_s_q, seg_s_d;
    logic [DIGITS-1:0]         an_m_q, an_m_d, an_s_q, an_s_d;
    logic [DIGITS-1:0]         an_last_q, an_last_d;
    logic                      bad_q, bad_d;
    slot_e                     slot_q, slot_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      scan_err_q, scan_err_d;
    logic [DIGITS-1:0][3:0]    nib_q, nib_d;
    logic [DIGITS-1:0]         cerr_q, cerr_d;
    logic [DIGITS-1:0][3:0]    match_q, match_d;
    out_e                      out_st_q, out_st_d;
    logic [WORD_W-1:0]         hex_q, hex_d;
    logic [DIGITS-1:0]         err_q, err_d;
    logic                      sent_vld_q, sent_vld_d;

    logic [6:0]                seg_lit_c;
    logic [4:0]                dec_c;
    logic                      an_nz_c, an_onehot_c, capture_c, cand_c;
    logic [DIGITS-1:0]         qual_c;
    logic [WORD_W-1:0]         word_c;
    logic                      new_dp_c;
    logic [DIGITS-1:0]         cur_dp_c, sent_dp_c;

`ifdef SEG7_SCAN_DP_CAPTURE_EN
    logic                      dp_m_q, dp_m_d, dp_s_q, dp_s_d;
    logic [DIGITS-1:0]         dp_q, dp_d, dp_out_q, dp_out_d;
    assign new_dp_c  = (SEG_ACTIVE_LOW != 0) ? ~dp_s_q : dp_s_q;
    assign cur_dp_c  = dp_q;
    assign sent_dp_c = dp_out_q;
    assign dp_out    = dp_out_q;
`else
    assign new_dp_c  = 1'b0;
    assign cur_dp_c  = '0;
    assign sent_dp_c = '0;
`endif

    // Two-flop synchronizers; segments and strobes share the same delay so they stay aligned.
    always_comb begin
        seg_m_d = seg_in;
        seg_s_d = seg_m_q;
        an_m_d  = an_in;
        an_s_d  = an_m_q;
`ifdef SEG7_SCAN_DP_CAPTURE_EN
        dp_m_d  = dp_in;
        dp_s_d  = dp_m_q;
`endif
    end

    assign seg_lit_c   = (SEG_ACTIVE_LOW != 0) ? ~seg_s_q : seg_s_q;
    assign dec_c       = decode_glyph(seg_lit_c);
    assign an_nz_c     = |an_s_q;
    assign an_onehot_c = an_nz_c && ((an_s_q & (an_s_q - DIGITS'(1))) == '0);

    // Slot FSM: one capture per stable strobe slot, SETTLE_CYC cycles after the strobe changes.
    always_comb begin
        slot_d     = slot_q;
        cnt_d      = cnt_q;
        capture_c  = 1'b0;
        an_last_d  = an_s_q;
        bad_d      = an_nz_c && !an_onehot_c;
        scan_err_d = 1'b0;
        if (!an_onehot_c) begin
            slot_d     = SLOT_IDLE;
            cnt_d      = '0;
            scan_err_d = bad_d && !bad_q;
        end else if (an_s_q != an_last_q) begin
            slot_d = SLOT_SETTLE;
            cnt_d  = '0;
        end else if (slot_q == SLOT_SETTLE) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(SETTLE_CYC - 1)) begin
                capture_c = 1'b1;
                slot_d    = SLOT_HOLD;
            end
        end
    end

    // Per-digit qualification: count consecutive identical captures, saturating at 15.
    always_comb begin
        nib_d   = nib_q;
        cerr_d  = cerr_q;
        match_d = match_q;
`ifdef SEG7_SCAN_DP_CAPTURE_EN
        dp_d    = dp_q;
`endif
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (capture_c && an_s_q[i]) begin
                if (dec_c[3:0] == nib_q[i] && dec_c[4] == cerr_q[i] && new_dp_c == cur_dp_c[i]) begin
                    match_d[i] = (match_q[i] == 4'hF) ? 4'hF : match_q[i] + 4'd1;
                end else begin
                    nib_d[i]   = dec_c[3:0];
                    cerr_d[i]  = dec_c[4];
                    match_d[i] = 4'd1;
`ifdef SEG7_SCAN_DP_CAPTURE_EN
                    dp_d[i]    = new_dp_c;
`endif
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DIGITS); i++) begin
            qual_c[i] = (match_q[i] >= 4'(STABLE_SCANS));
        end
    end

    // The presented word doubles as last_sent; sent_vld_q marks it meaningful.
    assign word_c = nib_q;
    assign cand_c = (&qual_c) &&
                    (!sent_vld_q || word_c != hex_q || cerr_q != err_q || cur_dp_c != sent_dp_c);

    // Output FSM: load on candidate while empty, hold until accepted.
    always_comb begin
        out_st_d   = out_st_q;
        hex_d      = hex_q;
        err_d      = err_q;
        sent_vld_d = sent_vld_q;
`ifdef SEG7_SCAN_DP_CAPTURE_EN
        dp_out_d   = dp_out_q;
`endif
        case (out_st_q)
            OUT_EMPTY: begin
                if (cand_c) begin
                    out_st_d   = OUT_FULL;
                    hex_d      = word_c;
                    err_d      = cerr_q;
                    sent_vld_d = 1'b1;
`ifdef SEG7_SCAN_DP_CAPTURE_EN
                    dp_out_d   = dp_q;
`endif
                end
            end
            OUT_FULL: begin
                if (out_ready) out_st_d = OUT_EMPTY;
            end
            default: out_st_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m_q    <= '0;
            seg_s_q    <= '0;
            an_m_q     <= '0;
            an_s_q     <= '0;
            an_last_q  <= '0;
            bad_q      <= 1'b0;
            slot_q     <= SLOT_IDLE;
            cnt_q      <= '0;
            scan_err_q <= 1'b0;
            nib_q      <= '0;
            cerr_q     <= '0;
            match_q    <= '0;
            out_st_q   <= OUT_EMPTY;
            hex_q      <= '0;
            err_q      <= '0;
            sent_vld_q <= 1'b0;
`ifdef SEG7_SCAN_DP_CAPTURE_EN
            dp_m_q     <= 1'b0;
            dp_s_q     <= 1'b0;
            dp_q       <= '0;
            dp_out_q   <= '0;
`endif
        end else begin
            seg_m_q    <= seg_m_d;
            seg_s_q    <= seg_s_d;
            an_m_q     <= an_m_d;
            an_s_q     <= an_s_d;
            an_last_q  <= an_last_d;
            bad_q      <= bad_d;
            slot_q     <= slot_d;
            cnt_q      <= cnt_d;
            scan_err_q <= scan_err_d;
            nib_q      <= nib_d;
            cerr_q     <= cerr_d;
            match_q    <= match_d;
            out_st_q   <= out_st_d;
            hex_q      <= hex_d;
            err_q      <= err_d;
            sent_vld_q <= sent_vld_d;
`ifdef SEG7_SCAN_DP_CAPTURE_EN
            dp_m_q     <= dp_m_d;
            dp_s_q     <= dp_s_d;
            dp_q       <= dp_d;
            dp_out_q   <= dp_out_d;
`endif
        end
    end

    assign hex_out   = hex_q;
    assign err_out   = err_q;
    assign out_valid = (out_st_q == OUT_FULL);
    assign scan_err  = scan_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder (DIGITS=4, SETTLE_CYC=8, STABLE_SCANS=3, active-low segments).
module tb_seg7_scan_decoder;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned SETTLE = 8;
    localparam int unsigned HOLD   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [6:0]        seg_in;
    logic [DIGITS-1:0] an_in;
    logic [15:0]       hex_out;
    logic [DIGITS-1:0] err_out;
    logic              out_valid;
    logic              out_ready;
    logic              scan_err;
`ifdef SEG7_SCAN_DP_CAPTURE_EN
    logic              dp_in;
    logic [DIGITS-1:0] dp_out;
`endif

    always #5 clk = ~clk;

    seg7_scan_decoder #(
        .DIGITS(DIGITS), .SETTLE_CYC(SETTLE), .STABLE_SCANS(3), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
`ifdef SEG7_SCAN_DP_CAPTURE_EN
        .dp_in(dp_in), .dp_out(dp_out),
`endif
        .hex_out(hex_out), .err_out(err_out), .out_valid(out_valid),
        .out_ready(out_ready), .scan_err(scan_err)
    );

    typedef struct {
        logic [27:0] segs;   // digit i pattern at [7i+6:7i], active-low
        logic [15:0] hex;
        logic [3:0]  err;
    } vec_t;

    vec_t vecs[8];
    int   n_checks = 0;
    int   n_errors = 0;

    // Output monitor, sampled on the falling edge.
    int          word_cnt = 0;
    logic [15:0] mon_hex = '0;
    logic [3:0]  mon_err = '0;
    logic        prev_valid = 1'b0;
    logic [15:0] prev_hex = '0;
    logic [3:0]  prev_err = '0;
    logic        unstable = 1'b0;
    logic        prev_se = 1'b0;
    int          se_pulses = 0;
    int          se_cycles = 0;

    always @(negedge clk) begin
        prev_valid <= out_valid;
        prev_hex   <= hex_out;
        prev_err   <= err_out;
        prev_se    <= scan_err;
        if (out_valid && !prev_valid) begin
            word_cnt <= word_cnt + 1;
            mon_hex  <= hex_out;
            mon_err  <= err_out;
        end
        if (out_valid && prev_valid && (hex_out != prev_hex || err_out != prev_err))
            unstable <= 1'b1;
        if (scan_err) begin
            se_cycles <= se_cycles + 1;
            if (!prev_se) se_pulses <= se_pulses + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic scan(input logic [27:0] segs, input int nscans, input int hold);
        for (int s = 0; s < nscans; s++) begin
            for (int d = 0; d < int'(DIGITS); d++) begin
                @(negedge clk);
                an_in    = '0;
                an_in[d] = 1'b1;
                seg_in   = segs[7*d +: 7];
                repeat (hold - 1) @(negedge clk);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, se_p0, se_c0;

        vecs[0] = '{segs: {7'h4F, 7'h08, 7'h06, 7'h01}, hex: 16'h1A30, err: 4'b0000};
        vecs[1] = '{segs: {7'h60, 7'h30, 7'h30, 7'h38}, hex: 16'hBEEF, err: 4'b0000};
        vecs[2] = '{segs: {7'h4F, 7'h08, 7'h7F, 7'h01}, hex: 16'h1A00, err: 4'b0010};
        vecs[3] = '{segs: {7'h12, 7'h06, 7'h4C, 7'h24}, hex: 16'h2345, err: 4'b0000};
        vecs[4] = '{segs: {7'h20, 7'h0F, 7'h00, 7'h04}, hex: 16'h6789, err: 4'b0000};
        vecs[5] = '{segs: {7'h31, 7'h42, 7'h30, 7'h38}, hex: 16'hCDEF, err: 4'b0000};
        vecs[6] = '{segs: {7'h01, 7'h01, 7'h01, 7'h01}, hex: 16'h0000, err: 4'b0000};
        vecs[7] = '{segs: {7'h7E, 7'h7F, 7'h00, 7'h01}, hex: 16'h0080, err: 4'b1100};

        rst_n     = 1'b0;
        seg_in    = 7'h7F;
        an_in     = '0;
        out_ready = 1'b1;
`ifdef SEG7_SCAN_DP_CAPTURE_EN
        dp_in     = 1'b1;
`endif
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_hex_out",   32'(hex_out),   32'd0);
        chk("rst_err_out",   32'(err_out),   32'd0);
        chk("rst_scan_err",  32'(scan_err),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: each display gives exactly one word with the expected value.
        for (int v = 0; v < 8; v++) begin
            base = word_cnt;
            scan(vecs[v].segs, 4, HOLD);
            repeat (4) tick();
            chk($sformatf("vec%0d_words", v), 32'(word_cnt - base), 32'd1);
            chk($sformatf("vec%0d_hex", v),   32'(mon_hex),         32'(vecs[v].hex));
            chk($sformatf("vec%0d_err", v),   32'(mon_err),         32'(vecs[v].err));
        end

        // Unchanged display: no further words.
        base = word_cnt;
        scan(vecs[7].segs, 3, HOLD);
        repeat (4) tick();
        chk("steady_no_repeat", 32'(word_cnt - base), 32'd0);

        // Glitches: a short strobe and a non-one-hot strobe pattern.
        base  = word_cnt;
        se_p0 = se_pulses;
        se_c0 = se_cycles;
        @(negedge clk);
        an_in  = 4'b0001;
        seg_in = 7'h4F;
        repeat (SETTLE - 2) @(negedge clk);
        an_in  = 4'b0011;
        repeat (4) @(negedge clk);
        scan(vecs[7].segs, 2, HOLD);
        repeat (4) tick();
        chk("glitch_words",       32'(word_cnt - base),   32'd0);
        chk("glitch_se_pulses",   32'(se_pulses - se_p0), 32'd1);
        chk("glitch_se_cycles",   32'(se_cycles - se_c0), 32'd1);
        chk("glitch_out_valid",   32'(out_valid),         32'd0);

        // A digit alternating every scan never qualifies.
        base = word_cnt;
        for (int s = 0; s < 6; s++)
            scan({7'h4F, 7'h08, 7'h06, ((s % 2) != 0) ? 7'h4F : 7'h01}, 1, HOLD);
        repeat (4) tick();
        chk("alt_words",     32'(word_cnt - base), 32'd0);
        chk("alt_out_valid", 32'(out_valid),       32'd0);

        // Backpressure: word held while display changes, next word 2 cycles after accept.
        out_ready = 1'b0;
        scan(vecs[0].segs, 4, HOLD);
        repeat (4) tick();
        chk("bp_valid_1a30", 32'(out_valid), 32'd1);
        chk("bp_hex_1a30",   32'(hex_out),   32'h1A30);
        scan(vecs[1].segs, 4, HOLD);
        repeat (4) tick();
        chk("bp_hold_hex",   32'(hex_out),   32'h1A30);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_stable",     32'(unstable),  32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("bp_gap_valid",  32'(out_valid), 32'd0);
        tick();
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_hex",   32'(hex_out),   32'hBEEF);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset while a word is pending.
        scan(vecs[3].segs, 4, HOLD);
        repeat (4) tick();
        chk("rh_pre_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rh_valid", 32'(out_valid), 32'd0);
        chk("rh_hex",   32'(hex_out),   32'd0);
        chk("rh_err",   32'(err_out),   32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        base      = word_cnt;
        scan(vecs[3].segs, 2, HOLD);
        repeat (4) tick();
        chk("rh_requal_early", 32'(word_cnt - base), 32'd0);
        scan(vecs[3].segs, 2, HOLD);
        repeat (4) tick();
        chk("rh_requal_words", 32'(word_cnt - base), 32'd1);
        chk("rh_requal_hex",   32'(mon_hex),         32'h2345);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
